router_output_arbiter: RTL and testbench
========================================

ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, flit width in bits.
REQ-002 The block SHALL have parameter NREQ, default 5, number of requesters (N, S, E, W, PE).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port polarity  input  1  current virtual-channel phase (0 even, 1 odd).
REQ-006 The block SHALL have port req  input  NREQ  per-requester flit-pending flag.
REQ-007 The block SHALL have port req_vc  input  NREQ  per-requester head-flit VC bit.
REQ-008 The block SHALL have port data_in  input  NREQ*DATA_W  packed flits, requester i at bits [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port out_ready  input  1  downstream channel can accept a flit this cycle.
REQ-010 The block SHALL have port grant  output  NREQ  one-hot combinational grant; flit of granted requester consumed at this edge.
REQ-011 The block SHALL have port send_out  output  1  registered valid for data_out.
REQ-012 The block SHALL have port data_out  output  DATA_W  registered forwarded flit.
REQ-013 The block SHALL have port vc_out  output  1  registered VC of forwarded flit.
REQ-014 The block SHALL have port flit_cnt  output  16  registered count of forwarded flits.

Function
REQ-015 eligible[i] SHALL be req[i] AND (req_vc[i] == polarity).
REQ-016 grant SHALL be all-zero when reset is low, out_ready is low, or no requester is eligible.
REQ-017 Otherwise grant SHALL be one-hot on the first eligible index searched from pointer upward, wrapping NREQ-1 -> 0.
REQ-018 pointer SHALL be a register in 0..NREQ-1, updated only on a cycle with non-zero grant, to (winner+1), wrapping NREQ-1 -> 0.
REQ-019 On a granting edge: send_out <= 1, data_out <= winner's data_in slice, vc_out <= polarity, flit_cnt <= flit_cnt+1.
REQ-020 On a non-granting edge: send_out <= 0, data_out <= 0, vc_out <= 0; flit_cnt and pointer hold.
REQ-021 Latency SHALL be exactly one cycle from grant to send_out/data_out.
REQ-022 flit_cnt SHALL wrap 16'hFFFF -> 16'h0000 with no flag.
REQ-023 Ineligible requests (VC mismatch) SHALL neither be granted nor move the pointer.
REQ-024 out_ready falling while req is held SHALL suppress grant with no state change other than REQ-020 outputs.
REQ-025 At most one grant SHALL be issued per cycle; no flit is ever forwarded twice.

Reset
REQ-026 With reset low at a rising edge: pointer=0, send_out=0, data_out=0, vc_out=0, flit_cnt=0.
REQ-027 Reset asserted mid-stream SHALL discard the in-flight output flit; grant is forced zero that cycle.
REQ-028 The first cycle after reset deasserts SHALL arbitrate normally from pointer 0.

Configuration
REQ-029 Macro ROUTER_ARB_ROUND_ROBIN_EN defined: behaviour per REQ-017/REQ-018.
REQ-030 Macro ROUTER_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest eligible index wins; pointer absent and treated as constant 0.

Verification
REQ-031 Reset low 2 cycles, then high -> send_out=0, data_out=0, flit_cnt=0, grant=0.
REQ-032 ROUTER_ARB_ROUND_ROBIN_EN defined, req=5'b11111, req_vc all equal polarity each cycle, out_ready=1, data_in[i]=64'h10+i -> data_out sequence 10,11,12,13,14,10; flit_cnt=6.
REQ-033 req=5'b00101 with req_vc=5'b00100, polarity=0 -> grant=5'b00001; polarity=1 -> grant=5'b00100, vc_out=1 next cycle.
REQ-034 req=5'b00010 held, out_ready low for 2 cycles then high -> grant=0 and send_out=0 for 2 cycles, then grant=5'b00010, send_out=1 with requester-1 flit.
REQ-035 Macro undefined, req=5'b10001 continuous, matching VC, out_ready=1 -> grant=5'b00001 every cycle; requester 4 never granted.
REQ-036 flit_cnt preloaded via 65535 grants -> next grant yields flit_cnt=0; reset asserted on a granting cycle -> send_out=0 next cycle.

Source files
------------

// File: rtl/router_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : router_output_arbiter
// Description : Output-port arbiter for a mesh router. It picks one requester
//               per cycle whose head-flit VC matches the current phase, and
//               forwards that requester's flit through a one-cycle register
//               stage together with its VC and a running flit count.
//               Define ROUTER_ARB_ROUND_ROBIN_EN for round-robin arbitration.
//               Leave it undefined for fixed priority, where the lowest
//               eligible index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module router_output_arbiter #(
    parameter int DATA_W = 64,
    parameter int NREQ   = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_vc,
    input  logic [NREQ*DATA_W-1:0] data_in,
    input  logic                   out_ready,
    output logic [NREQ-1:0]        grant,
    output logic                   send_out,
    output logic [DATA_W-1:0]      data_out,
    output logic                   vc_out,
    output logic [15:0]            flit_cnt
);

    localparam int              PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NREQ - 1);

    logic [NREQ-1:0]   w_eligible;
    logic              w_any;
    logic [PTR_W-1:0]  w_win;
    logic [DATA_W-1:0] w_data;

    logic              r_send;
    logic [DATA_W-1:0] r_data;
    logic              r_vc;
    logic [15:0]       r_cnt;

    // A requester competes only when its head flit sits on the active VC.
    assign w_eligible = req & ~(req_vc ^ {NREQ{polarity}});

`ifdef ROUTER_ARB_ROUND_ROBIN_EN
    localparam logic [PTR_W:0] c_NREQ_W = (PTR_W + 1)'(NREQ);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   w_sum;

    // Round-robin search: scan upward from the pointer and wrap past NREQ-1.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_sum = '0;
        if (reset && out_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
                if (w_sum >= c_NREQ_W) begin
                    w_sum = w_sum - c_NREQ_W;
                end
                if (!w_any && w_eligible[w_sum[PTR_W-1:0]]) begin
                    w_any = 1'b1;
                    w_win = w_sum[PTR_W-1:0];
                end
            end
        end
    end

    // The pointer moves only on a grant, to one past the winner.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_win == c_LAST) ? '0 : w_win + 1'b1;
        end
    end
`else
    // Fixed-priority search: the lowest eligible index wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        if (reset && out_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_any && w_eligible[k]) begin
                    w_any = 1'b1;
                    w_win = PTR_W'(k);
                end
            end
        end
    end
`endif

    // Decode the winner into a one-hot grant and select its flit.
    always_comb begin
        grant  = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_any && (w_win == PTR_W'(i))) begin
                grant[i] = 1'b1;
                w_data   = data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage: register the granted flit. Idle cycles drive zeros.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_send <= 1'b0;
            r_data <= '0;
            r_vc   <= 1'b0;
            r_cnt  <= '0;
        end else if (w_any) begin
            r_send <= 1'b1;
            r_data <= w_data;
            r_vc   <= polarity;
            r_cnt  <= r_cnt + 16'd1;
        end else begin
            r_send <= 1'b0;
            r_data <= '0;
            r_vc   <= 1'b0;
        end
    end

    assign send_out = r_send;
    assign data_out = r_data;
    assign vc_out   = r_vc;
    assign flit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_router_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_output_arbiter
// Description : Self-checking bench for router_output_arbiter. The reference
//               model tracks the arbitration pointer and flit count with plain
//               integer arithmetic. It follows ROUTER_ARB_ROUND_ROBIN_EN in
//               the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_output_arbiter;

    localparam int DATA_W = 64;
    localparam int NREQ   = 5;

`ifdef ROUTER_ARB_ROUND_ROBIN_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   polarity;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_vc;
    logic [NREQ*DATA_W-1:0] data_in;
    logic                   out_ready;
    logic [NREQ-1:0]        grant;
    logic                   send_out;
    logic [DATA_W-1:0]      data_out;
    logic                   vc_out;
    logic [15:0]            flit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int          m_ptr  = 0;
    int unsigned m_cnt  = 0;
    logic        m_send = 1'b0;
    logic [63:0] m_data = '0;
    logic        m_vc   = 1'b0;
    logic [NREQ-1:0] obs_grant;

    router_output_arbiter #(.DATA_W(DATA_W), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .req       (req),
        .req_vc    (req_vc),
        .data_in   (data_in),
        .out_ready (out_ready),
        .grant     (grant),
        .send_out  (send_out),
        .data_out  (data_out),
        .vc_out    (vc_out),
        .flit_cnt  (flit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Winner index by the arbitration rule, or -1 when nothing is granted.
    function automatic int model_winner(input logic r, input logic pol,
                                        input logic [NREQ-1:0] rq,
                                        input logic [NREQ-1:0] vc,
                                        input logic rdy);
        int idx;
        if (!r || !rdy) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (rq[idx] && (vc[idx] == pol)) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check the combinational grant, clock, check the outputs.
    task automatic cyc(input logic r, input logic pol, input logic [NREQ-1:0] rq,
                       input logic [NREQ-1:0] vc, input logic rdy);
        int w;
        logic [NREQ-1:0] eg;
        @(negedge clk);
        reset = r; polarity = pol; req = rq; req_vc = vc; out_ready = rdy;
        #1;
        w  = model_winner(r, pol, rq, vc, rdy);
        eg = (w < 0) ? '0 : NREQ'(1) << w;
        obs_grant = grant;
        chk("grant", 64'(grant), 64'(eg));
        @(posedge clk);
        #1;
        if (!r) begin
            m_ptr = 0; m_cnt = 0; m_send = 0; m_data = '0; m_vc = 0;
        end else if (w >= 0) begin
            m_send = 1; m_data = data_in[w*DATA_W +: DATA_W]; m_vc = pol;
            m_cnt  = (m_cnt + 1) % 65536;
            if (c_RR) m_ptr = (w + 1) % NREQ;
        end else begin
            m_send = 0; m_data = '0; m_vc = 0;
        end
        chk("send_out", 64'(send_out), 64'(m_send));
        chk("data_out", data_out, m_data);
        chk("vc_out",   64'(vc_out), 64'(m_vc));
        chk("flit_cnt", 64'(flit_cnt), 64'(m_cnt));
    endtask

    initial begin
        reset = 1'b0; polarity = 1'b0; req = '0; req_vc = '0; out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) data_in[i*DATA_W +: DATA_W] = 64'h10 + 64'(i);

        // Reset held low for two cycles while requests are pending.
        cyc(1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1);
        cyc(1'b0, 1'b0, 5'b11111, 5'b00000, 1'b1);
        chk("reset_flit_cnt", 64'(flit_cnt), 64'h0);
        chk("reset_send_out", 64'(send_out), 64'h0);

        // All requesters on the active VC for six cycles.
        for (int c = 0; c < 6; c++) cyc(1'b1, c[0], 5'b11111, {NREQ{c[0]}}, 1'b1);
        chk("burst_flit_cnt", 64'(flit_cnt), 64'd6);
        chk("burst_last_data", data_out, 64'h10);

        // VC filter: polarity 0 selects requester 0, polarity 1 selects requester 2.
        cyc(1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1);
        cyc(1'b1, 1'b0, 5'b00101, 5'b00100, 1'b1);
        chk("vc_even_grant", 64'(obs_grant), 64'b00001);
        cyc(1'b1, 1'b1, 5'b00101, 5'b00100, 1'b1);
        chk("vc_odd_grant", 64'(obs_grant), 64'b00100);
        chk("vc_odd_vc_out", 64'(vc_out), 64'h1);

        // out_ready low for two cycles, then high, while requester 1 is held.
        cyc(1'b1, 1'b0, 5'b00010, 5'b00000, 1'b0);
        cyc(1'b1, 1'b0, 5'b00010, 5'b00000, 1'b0);
        chk("stall_send_out", 64'(send_out), 64'h0);
        cyc(1'b1, 1'b0, 5'b00010, 5'b00000, 1'b1);
        chk("stall_release_grant", 64'(obs_grant), 64'b00010);
        chk("stall_release_data", data_out, 64'h11);

        // Requesters 0 and 4 held continuously.
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 5'b10001, 5'b00000, 1'b1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                data_in[i*DATA_W +: DATA_W] = {$urandom, $urandom};
            cyc(($urandom_range(0, 29) != 0), 1'($urandom), NREQ'($urandom),
                NREQ'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Drive the flit count up to 16'hFFFF, then wrap it to zero.
        while (m_cnt != 16'hFFFF) cyc(1'b1, 1'b0, 5'b00001, 5'b00000, 1'b1);
        chk("pre_wrap_cnt", 64'(flit_cnt), 64'hFFFF);
        cyc(1'b1, 1'b0, 5'b00001, 5'b00000, 1'b1);
        chk("wrap_cnt", 64'(flit_cnt), 64'h0);

        // Reset lands on a cycle that would otherwise grant.
        cyc(1'b1, 1'b0, 5'b00001, 5'b00000, 1'b1);
        cyc(1'b0, 1'b0, 5'b00001, 5'b00000, 1'b1);
        chk("reset_midstream_send", 64'(send_out), 64'h0);
        cyc(1'b1, 1'b0, 5'b11111, 5'b00000, 1'b1);
        chk("post_reset_grant", 64'(obs_grant), 64'b00001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
